// File: rtl/decode_ctrl.sv
// decode_ctrl
// Sequencer between the fetch stage and a multi-cycle instruction decoder.
// Accepts one instruction at a time and holds it on the decoder input. It
// drives the decoder request, captures the decoded fields on the decoder's
// one-cycle response pulse and offers them to execute on a valid/ready port.
// Also provides flush, a sticky timeout flag and a retired-decode counter.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_valid/if_ready/if_instr/if_pc   fetch handshake and payload
//   dec_instruction               held instruction to the decoder
//   dec_req_valid, dec_resp_ready decoder request / decoder idle
//   dec_resp_valid, dec_*         decoder one-cycle result and fields
//   id_valid/id_ready, id_*       registered decoded bundle to execute
//   flush                         discard in-flight work
//   err_timeout, err_clr          sticky timeout flag and its clear
//   decode_count                  number of completed id handshakes
module decode_ctrl #(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  output logic [31:0]          dec_instruction,
  output logic                 dec_req_valid,
  input  logic                 dec_resp_ready,
  input  logic                 dec_resp_valid,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic [6:0]           dec_opcode,
  input  logic [2:0]           dec_funct3,
  input  logic [6:0]           dec_funct7,
  input  logic [31:0]          dec_imm,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic [31:0]          id_imm,
  output logic [4:0]           id_rs1,
  output logic [4:0]           id_rs2,
  output logic [4:0]           id_rd,
  output logic [6:0]           id_opcode,
  output logic [2:0]           id_funct3,
  output logic [6:0]           id_funct7,
  input  logic                 flush,
  output logic                 err_timeout,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] decode_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  // Last wait-counter value that still counts as "in time": the counter is
  // cleared on entry to WAIT, so hitting this value without a response means
  // TIMEOUT cycles have been spent waiting.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic [31:0]          instr_reg, pc_reg;
  logic [7:0]           wait_cnt_reg;
  logic                 err_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  logic load_fetch, capture, cnt_clr, cnt_inc, set_err, count_inc;
  logic timeout_hit;

  assign timeout_hit = (wait_cnt_reg >= TO_LAST) && !dec_resp_valid;

  always_comb begin
    state_next    = state_reg;
    load_fetch    = 1'b0;
    capture       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    set_err       = 1'b0;
    count_inc     = 1'b0;
    if_ready      = 1'b0;
    dec_req_valid = 1'b0;
    id_valid      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if_ready = dec_resp_ready && !flush;
        if (if_valid && dec_resp_ready && !flush) begin
          load_fetch = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dec_req_valid = 1'b1;
        if (flush) begin
          // If the decoder takes the request this cycle its response must
          // still be absorbed; otherwise nothing is in flight.
          if (dec_resp_ready) begin
            cnt_clr    = 1'b1;
            state_next = S_DRAIN;
          end else begin
            state_next = S_IDLE;
          end
        end else if (dec_resp_ready) begin
          cnt_clr    = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_inc = 1'b1;
        if (flush) begin
          // A response arriving in the flush cycle is already drained.
          state_next = dec_resp_valid ? S_IDLE : S_DRAIN;
        end else if (dec_resp_valid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        id_valid = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else if (id_ready) begin
          count_inc  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Flush here changes nothing: the controller is already discarding.
        cnt_inc = 1'b1;
        if (dec_resp_valid) begin
          state_next = S_IDLE;
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Handshake outputs are forced low while reset is asserted.
    if (rst) begin
      if_ready      = 1'b0;
      dec_req_valid = 1'b0;
      id_valid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      instr_reg    <= '0;
      pc_reg       <= '0;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
      count_reg    <= '0;
      id_pc        <= '0;
      id_instr     <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_opcode    <= '0;
      id_funct3    <= '0;
      id_funct7    <= '0;
    end else begin
      state_reg <= state_next;

      // Instruction stays frozen from ISSUE until the next fetch: the decoder
      // decodes its live input during the response pulse.
      if (load_fetch) begin
        instr_reg <= if_instr;
        pc_reg    <= if_pc;
      end

      if (cnt_clr) begin
        wait_cnt_reg <= '0;
      end else if (cnt_inc) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      if (capture) begin
        id_pc     <= pc_reg;
        id_instr  <= instr_reg;
        id_imm    <= dec_imm;
        id_rs1    <= dec_rs1;
        id_rs2    <= dec_rs2;
        id_rd     <= dec_rd;
        id_opcode <= dec_opcode;
        id_funct3 <= dec_funct3;
        id_funct7 <= dec_funct7;
      end

      // A new timeout wins over a simultaneous clear.
      if (set_err) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end

      if (count_inc) begin
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign dec_instruction = instr_reg;
  assign err_timeout     = err_reg;
  assign decode_count    = count_reg;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl with a behavioural multi-cycle decoder.
// Stimulus pushes hand-computed expected bundles into a queue; a monitor pops
// and compares on every id handshake.
module tb_decode_ctrl;
  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid, if_ready;
  logic [31:0]   if_instr, if_pc;
  logic [31:0]   dec_instruction;
  logic          dec_req_valid, dec_resp_ready, dec_resp_valid;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic [6:0]    dec_opcode, dec_funct7;
  logic [2:0]    dec_funct3;
  logic [31:0]   dec_imm;
  logic          id_valid, id_ready;
  logic [31:0]   id_pc, id_instr, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [6:0]    id_opcode, id_funct7;
  logic [2:0]    id_funct3;
  logic          flush, err_timeout, err_clr;
  logic [CW-1:0] decode_count;

  always #5 clk = ~clk;

  decode_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .dec_instruction(dec_instruction), .dec_req_valid(dec_req_valid),
    .dec_resp_ready(dec_resp_ready), .dec_resp_valid(dec_resp_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
    .dec_imm(dec_imm),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .flush(flush), .err_timeout(err_timeout), .err_clr(err_clr),
    .decode_count(decode_count)
  );

  // ---------------- decoder model: delay D, optional "never respond" -------
  int   dly = 4;
  bit   no_resp = 1'b0;
  logic busy;
  int   rem;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      rem  <= 0;
    end else if (busy) begin
      if (rem == 0) busy <= 1'b0;
      else rem <= rem - 1;
    end else if (dec_req_valid && !no_resp) begin
      busy <= 1'b1;
      rem  <= dly;
    end
  end

  assign dec_resp_ready = !busy;
  assign dec_resp_valid = busy && (rem == 0);
  assign dec_rd     = dec_instruction[11:7];
  assign dec_rs1    = dec_instruction[19:15];
  assign dec_rs2    = dec_instruction[24:20];
  assign dec_opcode = dec_instruction[6:0];
  assign dec_funct3 = dec_instruction[14:12];
  assign dec_funct7 = dec_instruction[31:25];
  assign dec_imm    = {{20{dec_instruction[31]}}, dec_instruction[31:20]};

  // ---------------- hand-decoded vectors ----------------
  // 0: addi x1,x0,5   1: addi x2,x0,-1   2: addi x6,x5,10   3: lw x4,-2048(x3)
  logic [31:0] v_instr [4] = '{32'h00500093, 32'hFFF00113, 32'h00A28313, 32'h8001A203};
  logic [31:0] v_imm   [4] = '{32'h00000005, 32'hFFFFFFFF, 32'h0000000A, 32'hFFFFF800};
  logic [4:0]  v_rd    [4] = '{5'd1, 5'd2, 5'd6, 5'd4};
  logic [4:0]  v_rs1   [4] = '{5'd0, 5'd0, 5'd5, 5'd3};
  logic [4:0]  v_rs2   [4] = '{5'd5, 5'd31, 5'd10, 5'd0};
  logic [6:0]  v_op    [4] = '{7'h13, 7'h13, 7'h13, 7'h03};
  logic [2:0]  v_f3    [4] = '{3'd0, 3'd0, 3'd0, 3'd2};
  logic [6:0]  v_f7    [4] = '{7'h00, 7'h7F, 7'h00, 7'h40};

  typedef struct {
    logic [127:0] bundle;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] id_bundle();
    return {id_pc, id_instr, id_imm, id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7};
  endfunction

  task automatic push_exp(input int i, input logic [31:0] pc);
    exp_t e;
    e.bundle = {pc, v_instr[i], v_imm[i], v_rs1[i], v_rs2[i], v_rd[i], v_op[i], v_f3[i], v_f7[i]};
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", {96'd0, id_pc}, 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("handshake pc=%08h instr=%08h imm=%08h rd=%0d rs1=%0d count_before=%0d",
                 id_pc, id_instr, id_imm, id_rd, id_rs1, decode_count);
        check("id_bundle", id_bundle(), e.bundle);
      end
    end
  end

  // ---------------- stimulus helpers (called at #1 after posedge) ----------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_handshake_outs", {if_ready, dec_req_valid, id_valid}, 3'b000);
    check("rst_regs", {id_bundle()}, 128'd0);
    check("rst_misc", {dec_instruction, err_timeout, decode_count}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns at #1 after the handshake edge, i.e. in cycle 1 of the transaction.
  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    bit acc = 1'b0;
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = if_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if_valid = 1'b0;
    if (!acc) check("fetch_accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int first_v, nv, bad;
    logic req1;
    logic [127:0] snap;
    logic [CW-1:0] cnt_snap;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    id_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single decode, D=4: id_valid only in cycle 7
    id_ready = 1'b1;
    push_exp(0, 32'h100);
    fetch(v_instr[0], 32'h100);
    first_v = -1; nv = 0; req1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req1 = dec_req_valid;
      if (id_valid) begin
        nv++;
        if (first_v < 0) first_v = k;
      end
      @(posedge clk); #1;
    end
    check("t1_req_cycle1", req1, 1);
    check("t1_id_valid_cycle", first_v, 7);
    check("t1_id_valid_cycles", nv, 1);
    @(negedge clk);
    check("t1_count", decode_count, 1);
    @(posedge clk); #1;

    // Backpressure: hold id_ready low for 10 cycles
    id_ready = 1'b0;
    push_exp(2, 32'h104);
    fetch(v_instr[2], 32'h104);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (id_valid) break;
      @(posedge clk); #1;
    end
    check("t2_id_valid_seen", id_valid, 1);
    snap = id_bundle();
    cnt_snap = decode_count;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (id_bundle() !== snap || !id_valid || if_ready || decode_count !== cnt_snap) bad++;
    end
    check("t2_stable_under_backpressure", bad, 0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_count_after_release", decode_count, 2);
    check("t2_id_valid_dropped", id_valid, 0);
    @(posedge clk); #1;

    // Flush in WAIT (cycle 3): nothing emitted, if_ready low until drained
    fetch(v_instr[2], 32'h108);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bad = 0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      if (if_ready || id_valid) bad++;
      @(posedge clk); #1;
    end
    check("t3_blocked_while_draining", bad, 0);
    @(negedge clk);
    check("t3_if_ready_after_drain", if_ready, 1);
    @(posedge clk); #1;
    push_exp(1, 32'h10C);
    fetch(v_instr[1], 32'h10C);
    wait_drain();
    @(negedge clk);
    check("t3_count", decode_count, 3);
    @(posedge clk); #1;

    // Flush in HOLD with id_ready=1: no handshake
    fetch(v_instr[0], 32'h110);
    repeat (6) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("t4_in_hold", id_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t4_id_valid_dropped", id_valid, 0);
    check("t4_count_unchanged", decode_count, 3);
    @(posedge clk); #1;

    // Timeout: decoder drops the request
    no_resp = 1'b1;
    fetch(v_instr[2], 32'h114);
    repeat (15) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t5_no_err_before_timeout", err_timeout, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_err_set", err_timeout, 1);
    check("t5_if_ready_idle", if_ready, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", err_timeout, 0);
    @(posedge clk); #1;
    no_resp = 1'b0;

    // Counter wrap: 17 decodes on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push_exp(i % 4, 32'h200 + 32'(4 * i));
      fetch(v_instr[i % 4], 32'h200 + 32'(4 * i));
      wait_drain();
    end
    @(negedge clk);
    check("t6_count_wrapped", decode_count, 1);
    @(posedge clk); #1;

    // Reset in the middle of WAIT
    fetch(v_instr[3], 32'h300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_rst_regs", id_bundle(), 128'd0);
    check("t7_rst_misc", {dec_instruction, err_timeout, decode_count, if_ready, dec_req_valid, id_valid}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(3, 32'h304);
    fetch(v_instr[3], 32'h304);
    wait_drain();
    @(negedge clk);
    check("t7_count_after_recovery", decode_count, 1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
